// File: rtl/rf_muldiv_seq.sv
// RV32M multi-cycle sequencer: reads rs1/rs2, runs a shift-add multiply or a
// restoring divide, and writes the result back through the register file port.
module rf_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      src1,
    input  logic [4:0]      src2,
    input  logic [4:0]      dst,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic            rf_rs1_rd_en,
    output logic            rf_rs2_rd_en,
    output logic [4:0]      rf_rd,
    output logic            rf_rd_wd_en,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nxt;

    logic [2:0]        f3_q;
    logic [4:0]        src1_q, src2_q, dst_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] mcand, acc;
    logic [XLEN-1:0]   mplier;      // multiplier, or dividend shifting into quotient
    logic [XLEN-1:0]   divisor, prem, result;
    logic              neg_q, neg_r;

    logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN:0]     trial, diff;
    logic              fits;
    logic [XLEN-1:0]   prem_step, quo_step, quo_fix, rem_fix, final_res;
    logic              last_iter;

    // operand conditioning, valid while in READ
    always_comb begin
        is_div   = f3_q[2];
        sgn_a    = is_div ? ~f3_q[0] : (f3_q[1:0] != 2'b11);
        sgn_b    = is_div ? ~f3_q[0] : ~f3_q[1];
        a_neg    = sgn_a & rf_rs1_data[XLEN-1];
        b_neg    = sgn_b & rf_rs2_data[XLEN-1];
        a_mag    = a_neg ? (~rf_rs1_data + 1'b1) : rf_rs1_data;
        b_mag    = b_neg ? (~rf_rs2_data + 1'b1) : rf_rs2_data;
        div_zero = is_div && (rf_rs2_data == '0);
        div_ovf  = is_div && ~f3_q[0] && (rf_rs1_data == INT_MIN) && (rf_rs2_data == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = f3_q[1] ? rf_rs1_data : '1;
        else
            special_res = f3_q[1] ? '0 : INT_MIN;
    end

    // one iteration of multiply and divide, plus the sign-fixed final result
    always_comb begin
        acc_step  = mplier[0] ? (acc + mcand) : acc;
        trial     = {prem, mplier[XLEN-1]};
        diff      = trial - {1'b0, divisor};
        fits      = ~diff[XLEN];
        prem_step = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_step  = {mplier[XLEN-2:0], fits};
        prod_fix  = neg_q ? (~acc_step + 1'b1) : acc_step;
        quo_fix   = neg_q ? (~quo_step + 1'b1) : quo_step;
        rem_fix   = neg_r ? (~prem_step + 1'b1) : prem_step;
        if (is_div)
            final_res = f3_q[1] ? rem_fix : quo_fix;
        else if (f3_q[1:0] == 2'b00)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
        last_iter = (cnt == CNT_W'(XLEN-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = special ? WRITE : EXEC;
            EXEC:    if (last_iter) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dst_q   <= '0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            divisor <= '0;
            prem    <= '0;
            result  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    f3_q   <= funct3;
                    src1_q <= src1;
                    src2_q <= src2;
                    dst_q  <= dst;
                end
                READ: begin
                    cnt     <= '0;
                    acc     <= '0;
                    prem    <= '0;
                    mcand   <= {{XLEN{1'b0}}, a_mag};
                    mplier  <= is_div ? a_mag : b_mag;
                    divisor <= b_mag;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    if (special) result <= special_res;
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        prem   <= prem_step;
                        mplier <= quo_step;
                    end else begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (last_iter) result <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == WRITE);
    assign rf_rs1       = src1_q;
    assign rf_rs2       = src2_q;
    assign rf_rs1_rd_en = (state == READ);
    assign rf_rs2_rd_en = (state == READ);
    assign rf_rd        = dst_q;
    // the register file does not hardwire x0, so the write is masked here
    assign rf_rd_wd_en  = (state == WRITE) && (dst_q != 5'd0);
    assign rf_wdata     = result;

endmodule

// File: tb/tb_rf_muldiv_seq.sv
// Scoreboard bench for rf_muldiv_seq with a behavioural register file.
module tb_rf_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [4:0]  src1, src2, dst;
    logic        busy, done;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic        rf_rs1_rd_en, rf_rs2_rd_en, rf_rd_wd_en;
    logic [31:0] rf_wdata, rf_rs1_data, rf_rs2_data;

    logic [31:0] regs [32];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int exp_writes = 0;
    int dones = 0;
    int exp_dones = 0;

    rf_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .src1(src1), .src2(src2), .dst(dst), .busy(busy), .done(done),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_rd_en(rf_rs1_rd_en), .rf_rs2_rd_en(rf_rs2_rd_en),
        .rf_rd(rf_rd), .rf_rd_wd_en(rf_rd_wd_en), .rf_wdata(rf_wdata),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
    );

    always #5 clk = ~clk;

    assign rf_rs1_data = regs[rf_rs1];
    assign rf_rs2_data = regs[rf_rs2];

    always @(posedge clk) begin
        if (rf_rd_wd_en) begin
            regs[rf_rd] = rf_wdata;
            writes++;
        end
    end

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            dones++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done rd=%0d wdata=%h", rf_rd, rf_wdata);
            end else begin
                e = sb.pop_front();
                if (rf_rd !== e.rd || rf_wdata !== e.data || rf_rd_wd_en !== e.we)
                begin
                    errors++;
                    $display("FAIL result got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
                             rf_rd, rf_wdata, rf_rd_wd_en, e.rd, e.data, e.we);
                end
            end
        end
        if (!rst && rf_rd_wd_en && !done) begin
            checks++;
            errors++;
            $display("FAIL write_outside_done rd=%0d", rf_rd);
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, rf_rs1_rd_en, rf_rs2_rd_en, rf_rd_wd_en} !== 5'b0 ||
            rf_rs1 !== 5'd0 || rf_rs2 !== 5'd0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b en=%b%b%b rs1=%0d rs2=%0d rd=%0d wdata=%h want all 0",
                     name, busy, done, rf_rs1_rd_en, rf_rs2_rd_en, rf_rd_wd_en,
                     rf_rs1, rf_rs2, rf_rd, rf_wdata);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int lat, input bit poke);
        int n;
        regs[s1] = a;
        regs[s2] = b;
        sb.push_back('{d, want, d != 5'd0});
        exp_dones++;
        if (d != 5'd0) exp_writes++;
        funct3 = f3; src1 = s1; src2 = s2; dst = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        checks++;
        if (!(busy && rf_rs1_rd_en && rf_rs2_rd_en && rf_rs1 == s1 && rf_rs2 == s2)) begin
            errors++;
            $display("FAIL %s_read busy=%b en=%b%b rs1=%0d rs2=%0d want 1 11 %0d %0d",
                     name, busy, rf_rs1_rd_en, rf_rs2_rd_en, rf_rs1, rf_rs2, s1, s2);
        end
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            start = (poke && n == 12);
        end
        start = 1'b0;
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s_latency got %0d want %0d", name, n, lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after got %b want 0", name, busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; src1 = 5'd0; src2 = 5'd0; dst = 5'd0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul",      3'b000, 5'd5, 5'd6, 5'd7,  32'd7,        32'd6,        32'h0000002A, 34, 1'b0);
        run_op("mul_neg",  3'b000, 5'd1, 5'd2, 5'd3,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFF4, 34, 1'b0);
        run_op("mulh",     3'b001, 5'd5, 5'd6, 5'd8,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, 1'b0);
        run_op("mulhsu",   3'b010, 5'd5, 5'd6, 5'd9,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        run_op("mulhu",    3'b011, 5'd5, 5'd6, 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        run_op("div",      3'b100, 5'd5, 5'd6, 5'd11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        run_op("rem",      3'b110, 5'd5, 5'd6, 5'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        run_op("divu",     3'b101, 5'd5, 5'd6, 5'd13, 32'd100,      32'd7,        32'h0000000E, 34, 1'b0);
        run_op("remu",     3'b111, 5'd5, 5'd6, 5'd14, 32'd100,      32'd7,        32'h00000002, 34, 1'b0);
        run_op("divu_z",   3'b101, 5'd5, 5'd6, 5'd15, 32'h00001234, 32'd0,        32'hFFFFFFFF, 2,  1'b0);
        run_op("rem_z",    3'b110, 5'd5, 5'd6, 5'd16, 32'h00001234, 32'd0,        32'h00001234, 2,  1'b0);
        run_op("div_ovf",  3'b100, 5'd5, 5'd6, 5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1'b0);
        run_op("rem_ovf",  3'b110, 5'd5, 5'd6, 5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  1'b0);
        run_op("mul_x0",   3'b000, 5'd5, 5'd6, 5'd0,  32'd9,        32'd9,        32'h00000051, 34, 1'b0);
        run_op("mul_poke", 3'b000, 5'd5, 5'd6, 5'd19, 32'd3,        32'd5,        32'h0000000F, 34, 1'b1);

        checks++;
        if (regs[7] !== 32'h0000002A) begin
            errors++;
            $display("FAIL regfile_x7 got %h want 0000002a", regs[7]);
        end

        // abort an op in EXEC cycle 10
        regs[5] = 32'd11; regs[6] = 32'd13;
        funct3 = 3'b000; src1 = 5'd5; src2 = 5'd6; dst = 5'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_mid_exec");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (regs[20] !== 32'd0) begin
            errors++;
            $display("FAIL aborted_write got %h want 00000000", regs[20]);
        end

        run_op("div_after_rst", 3'b100, 5'd5, 5'd6, 5'd21, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 34, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        checks++;
        if (writes != exp_writes) begin
            errors++;
            $display("FAIL write_count got %0d want %0d", writes, exp_writes);
        end
        checks++;
        if (dones != exp_dones) begin
            errors++;
            $display("FAIL done_count got %0d want %0d", dones, exp_dones);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/rf_muldiv_seq.md
Name: rf_muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that owns the register file's read and write ports while an M-op runs.
- Accepts one op from decode, reads both source registers, and runs an iterative shift-add multiply or restoring divide.
- Writes the result back through the register file's single write port.
- Sits between decode and register_file; the core stalls while busy=1.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  op request; sampled only in IDLE.
- funct3  input  3  M-op select, per RV32M encoding (000 MUL … 111 REMU).
- src1  input  5  rs1 index.
- src2  input  5  rs2 index.
- dst  input  5  rd index.
- busy  output  1  high from the cycle after start is accepted until after WRITE.
- done  output  1  one-cycle pulse in WRITE.
- rf_rs1  output  5  register file rs1 address.
- rf_rs2  output  5  register file rs2 address.
- rf_rs1_rd_en  output  1  register file rs1 read enable.
- rf_rs2_rd_en  output  1  register file rs2 read enable.
- rf_rd  output  5  register file rd address.
- rf_rd_wd_en  output  1  register file write enable.
- rf_wdata  output  32  register file write data.
- rf_rs1_data  input  32  combinational read data for rs1.
- rf_rs2_data  input  32  combinational read data for rs2.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rf_rs1_rd_en, rf_rs2_rd_en and rf_rd_wd_en are 0; all addresses, rf_wdata and internal registers are 0.
- Reset mid-op aborts the op. No write occurs.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - start=1 latches funct3, src1, src2 and dst.
  - Next state is READ; busy=1 from the next cycle.
- READ (1 cycle):
  - Drive rf_rs1=src1, rf_rs2=src2 and both rd_en=1.
  - Capture operands at the posedge; read enables are 0 in every other state.
  - For signed ops (MUL/MULH/DIV/REM: both operands; MULHSU: rs1 only), store magnitudes and record the result sign.
  - Special case, detected on the captured operands: DIV/DIVU/REM/REMU with divisor 0, or DIV/REM with 0x80000000 / 0xFFFFFFFF. Load the result directly and go to WRITE; EXEC is skipped.
  - Otherwise go to EXEC with counter=0.
- EXEC (exactly XLEN=32 cycles, counter 0..31):
  - Multiply: 64-bit shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle; 33-bit partial remainder compare/subtract.
  - After counter=31, apply the sign fix (two's complement of the 64-bit product, quotient or remainder as required), then go to WRITE.
- Result select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Remainder sign follows the dividend.
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- WRITE (1 cycle):
  - rf_rd=dst, rf_wdata=result, done=1.
  - rf_rd_wd_en=1 unless dst==0. The register file does not hardwire x0, so the write must be suppressed here; done still pulses.
  - Next state is IDLE; busy=0 in the following cycle.
- Latency, with start sampled at edge T:
  - Normal op: done high in cycle T+34.
  - Special-case divide: done high in cycle T+2.
  - A new start may be accepted in the cycle after done.
- start while busy is ignored and not queued. start held high across done launches a new op from IDLE.
- rf_rd_wd_en is high only in WRITE. Addresses may hold stale values when their enables are 0.

Test Plan:
- MUL x5=7, x6=6, dst=x7 -> done at T+34; single write of 0x0000002A to x7; busy low at T+35.
- MULH with 0xFFFFFFFE (-2) × 3 -> writes 0xFFFFFFFF. MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> writes 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 0x0000000E. REMU 100/7 -> 0x00000002.
- DIVU x/0 with x=0x1234 -> quotient 0xFFFFFFFF, done at T+2. REM x/0 -> 0x00001234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- MUL with dst=x0 -> done pulses, rf_rd_wd_en stays 0 the whole op. start pulsed during EXEC -> ignored; exactly one done.
- Assert rst at EXEC cycle 10 -> all outputs 0 immediately; no write; a new op issued after reset completes correctly.
